mda_pattern_gen: RTL and testbench

MDA_PATTERN_GEN -- requirements
Module: mda_pattern_gen

---
 rtl/mda_pkg.sv | 33 +++
 rtl/mda_debounce.sv | 48 ++++
 rtl/mda_pattern_gen.sv | 126 ++++++++++++
 tb/tb_mda_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mda_pkg.sv
// Shared constants and types for the MDA test-pattern generator.
package mda_pkg;

  localparam int H_ACTIVE_DEF = 720;
  localparam int V_ACTIVE_DEF = 350;
  localparam int PAT_COUNT    = 6;

  typedef enum logic [2:0] {
    PAT_BORDER   = 3'd0,
    PAT_VLINES   = 3'd1,
    PAT_FILL     = 3'd2,
    PAT_CHECKER  = 3'd3,
    PAT_CHARGRID = 3'd4,
    PAT_BLINK    = 3'd5
  } pattern_e;

  // 9x14 character cell of the MDA text mode
  localparam logic [3:0] COL_LAST = 4'd8;
  localparam logic [3:0] ROW_LAST = 4'd13;

  typedef struct packed {
    logic video;
    logic intensity;
    logic hsync;
    logic vsync;
  } pix_t;

  // Indices 6 and 7 are illegal and recover to the first pattern.
  function automatic logic [2:0] next_pattern(input logic [2:0] cur);
    return (cur >= 3'(PAT_COUNT - 1)) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/mda_debounce.sv
// Two-flop synchroniser and level debouncer for an active-low push button.
module mda_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_n,
  output logic level,
  output logic fell
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p1;
  logic             sync_p2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // stage p1/p2: metastability synchroniser, idles released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p1 <= in_n;
      sync_p2 <= sync_p1;
    end
  end

  assign accept = (sync_p2 != level) && (cnt == CNT_LAST);
  assign fell   = accept && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync_p2 == level) begin
      cnt <= '0;
    end else if (accept) begin
      level <= sync_p2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mda_pattern_gen.sv
// MDA monitor test-pattern generator: button-selected pattern, rendered from the
// timing block's pixel coordinates and delayed two cycles together with the syncs.
module mda_pattern_gen
  import mda_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       valid,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       newframe,
  input  logic       newline,
  input  logic       btn_n,
  output logic       pin_v,
  output logic       pin_i,
  output logic       pin_hsync,
  output logic       pin_vsync,
  output logic [2:0] pattern
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 2);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 2);
  localparam logic [9:0] Y_HALF = 10'(V_ACTIVE / 2);

  logic       btn_level;
  logic       btn_fell;
  logic       press;
  logic       pending;
  logic [7:0] frame_cnt;
  logic [3:0] col_cnt;
  logic [3:0] row_cnt;
  logic       border;
  logic       pat_v;
  pix_t       raw;
  pix_t       pix_p1;
  pix_t       pix_p2;

  mda_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .in_n (btn_n),
    .level(btn_level),
    .fell (btn_fell)
  );

  assign press = btn_fell && btn_level;

  // A press is latched until the next frame start so the picture never changes mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= 3'd0;
      pending <= 1'b0;
    end else if (newframe && (pending || press)) begin
      pattern <= next_pattern(pattern);
      pending <= 1'b0;
    end else if (press) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
      col_cnt   <= 4'd0;
      row_cnt   <= 4'd0;
    end else begin
      if (newframe) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (!valid) begin
        col_cnt <= 4'd0;
      end else begin
        col_cnt <= (col_cnt == COL_LAST) ? 4'd0 : col_cnt + 4'd1;
      end
      if (newframe) begin
        row_cnt <= 4'd0;
      end else if (newline) begin
        row_cnt <= (row_cnt == ROW_LAST) ? 4'd0 : row_cnt + 4'd1;
      end
    end
  end

  assign border = (x < 10'd2) || (x > X_LAST) || (y < 10'd2) || (y > Y_LAST);

  always_comb begin
    pat_v = 1'b0;
    case (pattern)
      PAT_BORDER:   pat_v = border;
      PAT_VLINES:   pat_v = (x[3:0] == 4'd0);
      PAT_FILL:     pat_v = 1'b1;
      PAT_CHECKER:  pat_v = x[3] ^ y[3];
      PAT_CHARGRID: pat_v = (col_cnt == 4'd0) || (row_cnt == 4'd0);
      PAT_BLINK:    pat_v = border && frame_cnt[4];
      default:      pat_v = 1'b0;
    endcase
    raw.video     = valid && pat_v;
    raw.intensity = raw.video && (pattern == PAT_FILL) && (y < Y_HALF);
    raw.hsync     = hsync;
    raw.vsync     = vsync;
  end

  // stage p1 -> p2: video and syncs stay mutually aligned through both registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_p1 <= '0;
      pix_p2 <= '0;
    end else begin
      pix_p1 <= raw;
      pix_p2 <= pix_p1;
    end
  end

  assign pin_v     = pix_p2.video;
  assign pin_i     = pix_p2.intensity;
  assign pin_hsync = pix_p2.hsync;
  assign pin_vsync = pix_p2.vsync;

endmodule

// File: tb/tb_mda_pattern_gen.sv
// Scoreboard bench for mda_pattern_gen driven by a synthetic timing source.
module tb_mda_pattern_gen;

  localparam int DEB = 4;
  localparam int H   = 720;
  localparam int V   = 350;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       valid = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic       newframe = 1'b0, newline = 1'b0, btn_n = 1'b1;
  logic       pin_v, pin_i, pin_hsync, pin_vsync;
  logic [2:0] pattern;

  int n_chk = 0;
  int n_fail = 0;
  int frames = 0;

  mda_pattern_gen #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .valid(valid),
    .hsync(hsync), .vsync(vsync), .newframe(newframe), .newline(newline),
    .btn_n(btn_n), .pin_v(pin_v), .pin_i(pin_i), .pin_hsync(pin_hsync),
    .pin_vsync(pin_vsync), .pattern(pattern)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic v; logic i; logic hs; logic vs; } exp_t;
  exp_t q[$];
  exp_t e;
  exp_t got;
  logic hist [0:DEB];
  logic m_lvl = 1'b1, m_pend = 1'b0, m_acc, m_press, m_border, m_pv;
  int   m_pat = 0, m_fc = 0, m_col = 0, m_row = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i <= DEB; i++) hist[i] = 1'b1;
      m_lvl = 1'b1; m_pend = 1'b0; m_pat = 0; m_fc = 0; m_col = 0; m_row = 0;
    end else begin
      // the debouncer sees the button two edges late; accept after DEB differing samples
      m_acc = 1'b1;
      for (int i = 1; i <= DEB; i++) if (hist[i] == m_lvl) m_acc = 1'b0;
      m_press  = m_acc && m_lvl;
      m_border = (x < 2) || (x > H - 2) || (y < 2) || (y > V - 2);
      case (m_pat)
        0: m_pv = m_border;
        1: m_pv = (x % 16 == 0);
        2: m_pv = 1'b1;
        3: m_pv = ((x / 8) % 2) != ((y / 8) % 2);
        4: m_pv = (m_col == 0) || (m_row == 0);
        5: m_pv = m_border && ((m_fc / 16) % 2 == 1);
        default: m_pv = 1'b0;
      endcase
      e.v  = valid && m_pv;
      e.i  = e.v && (m_pat == 2) && (y < V / 2);
      e.hs = hsync;
      e.vs = vsync;
      q.push_back(e);
      if (m_acc) m_lvl = !m_lvl;
      if (newframe && (m_pend || m_press)) begin
        m_pat = (m_pat + 1) % 6;
        m_pend = 1'b0;
      end else if (m_press) begin
        m_pend = 1'b1;
      end
      if (newframe) m_fc = (m_fc + 1) % 256;
      m_col = valid ? (m_col + 1) % 9 : 0;
      if (newframe) m_row = 0;
      else if (newline) m_row = (m_row + 1) % 14;
      for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn_n;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sb_pattern", pattern, m_pat);
      if (q.size() >= 2) begin
        got = q.pop_front();
        chk("sb_pin_v", pin_v, got.v);
        chk("sb_pin_i", pin_i, got.i);
        chk("sb_pin_hsync", pin_hsync, got.hs);
        chk("sb_pin_vsync", pin_vsync, got.vs);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; hsync = 1'b0; vsync = 1'b0; newframe = 1'b0; newline = 1'b0;
  endtask

  task automatic frame();
    newframe = 1'b1;
    cyc();
    newframe = 1'b0;
    frames++;
  endtask

  task automatic press(input int nlow);
    btn_n = 1'b0;
    repeat (nlow) cyc();
    btn_n = 1'b1;
    repeat (8) cyc();
  endtask

  task automatic advance();
    press(6);
    frame();
  endtask

  task automatic pix(input int px, input int py, input logic ev, input logic ei, input string name);
    x = 10'(px); y = 10'(py); valid = 1'b1;
    cyc();
    valid = 1'b0;
    cyc();
    chk({name, "_v"}, pin_v, ev);
    chk({name, "_i"}, pin_i, ei);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pin_v", pin_v, 0);
    chk("rst_pin_hsync", pin_hsync, 0);
    chk("rst_pattern", pattern, 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    pix(1, 100, 1'b1, 1'b0, "p0_1_100");
    pix(2, 100, 1'b0, 1'b0, "p0_2_100");
    pix(719, 0, 1'b1, 1'b0, "p0_719_0");

    press(3);
    frame();
    chk("short_press_no_adv", pattern, 0);
    press(6);
    chk("press_waits_frame", pattern, 0);
    frame();
    chk("press_adv_0_1", pattern, 1);
    frame();
    chk("release_no_adv", pattern, 1);

    press(6);
    press(6);
    frame();
    chk("merge_two_presses", pattern, 2);
    frame();
    chk("merge_no_second", pattern, 2);

    repeat (3) cyc();
    x = 10'd100; y = 10'd100; valid = 1'b1;
    cyc();
    chk("lat_n1_pin_v", pin_v, 0);
    cyc();
    chk("lat_n2_pin_v", pin_v, 1);
    chk("lat_n2_pin_i", pin_i, 1);
    valid = 1'b0;
    repeat (3) cyc();
    hsync = 1'b1;
    cyc();
    hsync = 1'b0;
    chk("hs_lat1", pin_hsync, 0);
    cyc();
    chk("hs_lat2", pin_hsync, 1);
    cyc();
    chk("hs_lat3", pin_hsync, 0);

    pix(100, 174, 1'b1, 1'b1, "p2_y174");
    pix(100, 175, 1'b1, 1'b0, "p2_y175");

    repeat (3) advance();
    chk("reach_5", pattern, 5);
    for (int f = 0; f < 40; f++) begin
      frame();
      pix(0, 100, 1'(frames / 16 % 2), 1'b0, "blink");
    end
    advance();
    chk("wrap_5_0", pattern, 0);

    repeat (4) advance();
    chk("reach_4", pattern, 4);
    frame();
    newline = 1'b1;
    repeat (5) cyc();
    newline = 1'b0;
    y = 10'd20;
    for (int k = 0; k < 10; k++) begin
      x = 10'(16 + k); valid = 1'b1;
      cyc();
      if (k == 1) chk("p4_col0", pin_v, 1);
      if (k == 5) chk("p4_col4_row5", pin_v, 0);
    end
    idle();
    cyc();

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        btn_n = ~btn_n;
        hold = $urandom_range(1, 12);
      end
      hold--;
      valid    = ($urandom_range(0, 3) != 0);
      x        = 10'($urandom_range(0, 799));
      y        = 10'($urandom_range(0, 369));
      hsync    = ($urandom_range(0, 7) == 0);
      vsync    = ($urandom_range(0, 7) == 0);
      newframe = ($urandom_range(0, 49) == 0);
      newline  = ($urandom_range(0, 11) == 0);
      cyc();
    end
    idle();
    btn_n = 1'b1;
    repeat (4) cyc();

    valid = 1'b1; x = 10'd0; y = 10'd100; hsync = 1'b1; vsync = 1'b1;
    repeat (3) cyc();
    chk("pre_rst_hsync", pin_hsync, 1);
    chk("pre_rst_vsync", pin_vsync, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pin_v", pin_v, 0);
    chk("async_rst_pin_i", pin_i, 0);
    chk("async_rst_pin_hsync", pin_hsync, 0);
    chk("async_rst_pin_vsync", pin_vsync, 0);
    chk("async_rst_pattern", pattern, 0);
    idle();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    frame();
    chk("post_rst_no_adv", pattern, 0);
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
